// File: rtl/sm_sub_pipe.sv
// Two-stage pipelined sign-magnitude subtractor (c = a - b) with valid/ready handshake.
// Define SM_SUB_SAT_EN to saturate the magnitude on overflow instead of wrapping.
module sm_sub_pipe #(
    parameter int Q = 16,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         ovf
);

    localparam int M = N - 1;

    if (Q < 0 || Q >= N) begin : g_bad_q
        $error("sm_sub_pipe: Q must lie in [0, N-1]");
    end

    logic         s1_valid;
    logic         s2_valid;
    logic         s1_advance;
    logic         s1_sa;
    logic         s1_sb;
    logic         s1_age;
    logic [M-1:0] s1_ma;
    logic [M-1:0] s1_mb;
    logic [N-1:0] c_q;
    logic         ovf_q;

    logic [M-1:0] ma_in;
    logic [M-1:0] mb_in;
    logic         sa_in;
    logic         sb_in;

    logic [N-1:0] sum;
    logic [M-1:0] diff;
    logic [M-1:0] nxt_mag;
    logic         nxt_sign;
    logic         nxt_ovf;

    assign s1_advance = !s2_valid | out_ready;
    assign in_ready   = !s1_valid | s1_advance;
    assign out_valid  = s2_valid;
    assign c          = c_q;
    assign ovf        = ovf_q;

    // Effective signs: b's sign is inverted for subtraction; a zero magnitude is always +0.
    assign ma_in = a[M-1:0];
    assign mb_in = b[M-1:0];
    assign sa_in = a[N-1] & (|ma_in);
    assign sb_in = ~b[N-1] & (|mb_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sa    <= 1'b0;
            s1_sb    <= 1'b0;
            s1_age   <= 1'b0;
            s1_ma    <= '0;
            s1_mb    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sa  <= sa_in;
                s1_sb  <= sb_in;
                s1_age <= (ma_in >= mb_in);
                s1_ma  <= ma_in;
                s1_mb  <= mb_in;
            end
        end
    end

    always_comb begin
        sum      = {1'b0, s1_ma} + {1'b0, s1_mb};
        diff     = s1_age ? (s1_ma - s1_mb) : (s1_mb - s1_ma);
        nxt_mag  = diff;
        nxt_sign = s1_age ? s1_sa : s1_sb;
        nxt_ovf  = 1'b0;
        if (s1_sa == s1_sb) begin
            nxt_sign = s1_sa;
            nxt_ovf  = sum[M];
`ifdef SM_SUB_SAT_EN
            nxt_mag  = sum[M] ? '1 : sum[M-1:0];
`else
            nxt_mag  = sum[M-1:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            c_q      <= '0;
            ovf_q    <= 1'b0;
        end else if (s1_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                // Zero magnitude (equal operands or wrapped overflow) never carries a sign.
                c_q   <= {nxt_sign & (|nxt_mag), nxt_mag};
                ovf_q <= nxt_ovf;
            end
        end
    end

endmodule

// File: tb/tb_sm_sub_pipe.sv
// Directed self-checking bench for sm_sub_pipe with a scoreboard fed by accepted inputs.
// Honours SM_SUB_SAT_EN the same way as the design.
module tb_sm_sub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] c;
    logic        ovf;

    int total = 0;
    int bad = 0;
    logic [32:0] sb_q[$];

    sm_sub_pipe #(.Q(16), .N(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .c(c),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Reference: signed integer subtraction, then re-encode to sign-magnitude.
    function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
        longint va, vb, r, mag, lim;
        logic o, s;
        lim = longint'(1) <<< 31;
        va = longint'(x[30:0]);
        if (x[31]) va = -va;
        vb = longint'(y[30:0]);
        if (y[31]) vb = -vb;
        r = va - vb;
        mag = (r < 0) ? -r : r;
        o = (mag >= lim);
`ifdef SM_SUB_SAT_EN
        if (o) mag = lim - 1;
`else
        mag = mag % lim;
`endif
        s = (r < 0) && (mag != 0);
        return {o, s, mag[30:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) sb_q.push_back(model(a, b));
            if (out_valid && out_ready) begin
                logic [32:0] exp;
                exp = 'x;
                if (sb_q.size() != 0) exp = sb_q.pop_front();
                chk("scoreboard", {31'b0, ovf, c}, {31'b0, exp});
            end
        end
    end

    task automatic send_one(input logic [31:0] x, input logic [31:0] y,
                            input logic [32:0] exp, input string tag);
        int lat;
        a = x;
        b = y;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_rdy"}, {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd2);
        chk({tag, "_val"}, {31'b0, ovf, c}, {31'b0, exp});
        @(posedge clk);
        #1;
    endtask

    logic [31:0] va[4];
    logic [31:0] vb[4];
    logic [32:0] held;
    logic        have_held;
    logic        acc;
    int          idx;
    int          accepts;
    int          nout;
    int          first;
    int          last;
    int          stalls;
    int          stale;

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_c", {32'b0, c}, 64'd0);
        chk("rst_ovf", {63'b0, ovf}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

        send_one(32'h0003_0000, 32'h0001_0000, 33'h0_0002_0000, "sub_3_1");
        send_one(32'h0001_0000, 32'h0003_0000, 33'h0_8002_0000, "sub_1_3");
        send_one(32'h8002_0000, 32'h8002_0000, 33'h0_0000_0000, "no_neg_zero");
        send_one(32'h8000_0000, 32'h0000_0000, 33'h0_0000_0000, "neg0_minus_0");
        send_one(32'h8000_0003, 32'h8000_0005, 33'h0_0000_0002, "neg_neg");
        send_one(32'h8000_0004, 32'h0000_0001, 33'h0_8000_0005, "neg_add");
`ifdef SM_SUB_SAT_EN
        send_one(32'h7FFF_FFFF, 32'h8000_0001, 33'h1_7FFF_FFFF, "ovf_sat");
        send_one(32'hFFFF_FFFF, 32'h7FFF_FFFF, 33'h1_FFFF_FFFF, "ovf_sat_neg");
`else
        send_one(32'h7FFF_FFFF, 32'h8000_0001, 33'h1_0000_0000, "ovf_wrap");
        send_one(32'hFFFF_FFFF, 32'h7FFF_FFFF, 33'h1_FFFF_FFFE, "ovf_wrap_neg");
`endif

        // Backpressure: four back-to-back operands, output stalled for five cycles.
        for (int i = 0; i < 4; i++) begin
            va[i] = 32'h0001_0000 * (i + 5);
            vb[i] = 32'h8000_0100 + 32'(i);
        end
        out_ready = 1'b0;
        idx = 0;
        accepts = 0;
        have_held = 1'b0;
        held = '0;
        a = va[0];
        b = vb[0];
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid) begin
                if (have_held) chk("stall_hold", {31'b0, ovf, c}, {31'b0, held});
                held = {ovf, c};
                have_held = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                accepts++;
                idx++;
                a = va[idx % 4];
                b = vb[idx % 4];
            end
        end
        chk("stall_accepts", 64'(accepts), 64'd2);
        chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
        chk("stall_out_valid", {63'b0, out_valid}, 64'd1);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    a = va[idx];
                    b = vb[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        chk("stall_fed", 64'(idx), 64'd4);
        repeat (4) @(posedge clk);
        #1;
        chk("stall_drained", 64'(sb_q.size()), 64'd0);

        // Full throughput: 16 consecutive operand pairs with the output always ready.
        nout = 0;
        first = -1;
        last = -1;
        stalls = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc < 16) begin
                a = $urandom;
                b = $urandom;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid) begin
                nout++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (cyc < 16 && !in_ready) stalls++;
            @(posedge clk);
            #1;
        end
        chk("tput_count", 64'(nout), 64'd16);
        chk("tput_span", 64'(last - first), 64'd15);
        chk("tput_first", 64'(first), 64'd2);
        chk("tput_stalls", 64'(stalls), 64'd0);

        // Reset with two results in flight.
        out_ready = 1'b0;
        a = 32'h0009_0000;
        b = 32'h0001_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 32'h0007_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("inflight_valid", {63'b0, out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("midrst_c", {32'b0, c}, 64'd0);
        chk("midrst_ovf", {63'b0, ovf}, 64'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("no_stale", 64'(stale), 64'd0);
        @(posedge clk);
        #1;
        send_one(32'h0005_0000, 32'h0002_0000, 33'h0_0003_0000, "post_rst");

        repeat (3) @(posedge clk);
        #1;
        chk("final_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sm_sub_pipe.md
SM_SUB_PIPE -- requirements
Module: sm_sub_pipe

Interface
REQ-001 The block SHALL expose parameter Q, default 16: number of fractional bits (informational; it does not change the arithmetic).
REQ-002 The block SHALL expose parameter N, default 32: total word width in sign-magnitude format (bit N-1 = sign, bits N-2:0 = magnitude).
REQ-003 The block SHALL provide port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-004 The block SHALL provide port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL provide port in_valid, input, 1 bit: operand pair a/b is valid.
REQ-006 The block SHALL provide port in_ready, output, 1 bit: block accepts an operand pair this cycle.
REQ-007 The block SHALL provide port a, input, N bits: minuend, sign-magnitude.
REQ-008 The block SHALL provide port b, input, N bits: subtrahend, sign-magnitude.
REQ-009 The block SHALL provide port out_valid, output, 1 bit: c/ovf hold a valid result.
REQ-010 The block SHALL provide port out_ready, input, 1 bit: downstream consumes the result.
REQ-011 The block SHALL provide port c, output, N bits: a - b, sign-magnitude.
REQ-012 The block SHALL provide port ovf, output, 1 bit: magnitude overflow on this result.

Function
REQ-013 The block SHALL compute c = a - b by negating the sign of b, then applying sign-magnitude addition.
REQ-014 When the effective signs are equal, the result magnitude SHALL be |a|+|b| and the result sign SHALL be the sign of a.
REQ-015 When the effective signs differ, the result magnitude SHALL be the larger magnitude minus the smaller, with the sign of the larger operand.
REQ-016 Equal magnitudes with differing effective signs SHALL produce +0 (0x0), never -0.
REQ-017 An input -0 SHALL be treated as +0, and no output SHALL ever carry sign=1 with magnitude 0.
REQ-018 ovf SHALL be 1 exactly when |a|+|b| >= 2^(N-1) on the addition path; the subtraction path never sets ovf.
REQ-019 The block SHALL be a 2-stage pipeline.
  - Stage 1 registers the effective signs, the magnitude comparison result and the operands.
  - Stage 2 registers the magnitude, sign and ovf.
REQ-020 Latency SHALL be 2 cycles from an accepted input (in_valid & in_ready) to out_valid with no backpressure, with throughput of 1 result per cycle.
REQ-021 in_ready SHALL be asserted combinationally as (!s1_valid | s1_advance), where s1_advance = (!s2_valid | out_ready).
REQ-022 While out_valid=1 and out_ready=0, c, ovf and out_valid SHALL hold stable, and no accepted result SHALL be dropped or duplicated.
REQ-023 Simultaneous output consume and input accept in the same cycle SHALL sustain full throughput with no bubble.
REQ-024 in_valid=1 with in_ready=0 SHALL not consume the operands; a and b SHALL be resampled when in_ready rises.

Reset
REQ-025 Asserting rst_n low SHALL immediately and asynchronously clear both stage valid bits, out_valid=0, c=0 and ovf=0.
REQ-026 Reset mid-operation SHALL discard all in-flight results, and no stale result SHALL appear after release.
REQ-027 The block SHALL accept input on the first rising edge after rst_n deasserts.

Configuration
REQ-028 When macro SM_SUB_SAT_EN is defined, overflow SHALL clamp the magnitude to 2^(N-1)-1 (all ones), keep the computed sign, and assert ovf=1.
REQ-029 When SM_SUB_SAT_EN is undefined, overflow SHALL wrap the magnitude modulo 2^(N-1) and assert ovf=1; a wrapped magnitude of 0 SHALL force sign=0.

Verification
REQ-030 The bench SHALL cover the following directed scenarios (N=32, Q=16):
  - a=0x00030000 (3.0), b=0x00010000 (1.0), out_ready=1 -> c=0x00020000, ovf=0, out_valid exactly 2 cycles after accept.
  - a=0x00010000, b=0x00030000 -> c=0x80020000 (-2.0); a=0x80020000, b=0x80020000 -> c=0x00000000, no -0.
  - a=0x7FFFFFFF, b=0x80000001 -> with SM_SUB_SAT_EN: c=0x7FFFFFFF, ovf=1; without: c=0x00000000, ovf=1.
  - 4 back-to-back inputs with out_ready held 0 for 5 cycles -> in_ready drops after 2 accepts; all 4 results emerge in order, each held stable while stalled.
  - Continuous in_valid=1 and out_ready=1 for 16 cycles -> 16 results on consecutive cycles, no bubbles.
  - rst_n pulsed low mid-stream with 2 results in flight -> out_valid=0 immediately, no stale output after release, next input yields the correct result 2 cycles after accept.
